// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operand beat in, result beat out.
// The optional `sub` wire exists only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid,
      output a,
      output b,
      output cin,
`ifdef PIPELINED_ADDER_SUB_EN
      output sub,
`endif
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sum,
      input  cout,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  cin,
`ifdef PIPELINED_ADDER_SUB_EN
      input  sub,
`endif
      input  out_ready,
      output in_ready,
      output out_valid,
      output sum,
      output cout,
      output ovf
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two-operand adder: one CW-bit chunk per stage, carry registered between stages.
// Define PIPELINED_ADDER_SUB_EN to add a `sub` input selecting a - b.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input logic              clk,
   input logic              rst_n,
   pipelined_adder_if.slave bus
);
   localparam int unsigned CW   = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
   end

   // Per-stage state. Stage k holds operands (upper chunks still to be added), the sum
   // chunks 0..k already completed, the carry out of chunk k and the beat valid bit.
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] c_d;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic              ovf_q;
   logic              ovf_d;

   logic              stall;
   logic [WIDTH-1:0]  b_in;
   logic              cin_in;

`ifdef PIPELINED_ADDER_SUB_EN
   // a - b == a + ~b + 1; the forced carry-in replaces cin.
   always_comb begin
      b_in   = bus.sub ? ~bus.b : bus.b;
      cin_in = bus.sub | bus.cin;
   end
`else
   always_comb begin
      b_in   = bus.b;
      cin_in = bus.cin;
   end
`endif

   always_comb begin : p_stages
      logic [WIDTH-1:0] a_p;
      logic [WIDTH-1:0] b_p;
      logic [WIDTH-1:0] s_p;
      logic             c_p;
      logic             v_p;
      logic [CW:0]      chunk;
      a_p   = bus.a;
      b_p   = b_in;
      s_p   = '0;
      c_p   = cin_in;
      v_p   = bus.in_valid;
      chunk = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk = {1'b0, a_p[k*CW +: CW]} + {1'b0, b_p[k*CW +: CW]} + {{CW{1'b0}}, c_p};
         a_d[k] = a_p;
         b_d[k] = b_p;
         s_d[k] = s_p;
         s_d[k][k*CW +: CW] = chunk[CW-1:0];
         c_d[k] = chunk[CW];
         v_d[k] = v_p;
         a_p = a_q[k];
         b_p = b_q[k];
         s_p = s_q[k];
         c_p = c_q[k];
         v_p = v_q[k];
      end
      // Carry into the MSB is a^b^s there; overflow when it differs from carry out.
      ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         s_q   <= '{default: '0};
         c_q   <= '0;
         v_q   <= '0;
         ovf_q <= 1'b0;
      end else if (!stall) begin
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         c_q   <= c_d;
         v_q   <= v_d;
         ovf_q <= ovf_d;
      end
   end

   // Whole pipe freezes while the output beat is refused; bubbles only move when it is free.
   always_comb begin
      stall         = v_q[LAST] & ~bus.out_ready;
      bus.in_ready  = ~stall;
      bus.out_valid = v_q[LAST];
      bus.sum       = s_q[LAST];
      bus.cout      = c_q[LAST];
      bus.ovf       = ovf_q;
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: main 16/4 instance plus 8/1 and 32/8 instances.
// Define PIPELINED_ADDER_SUB_EN to also exercise subtract mode.
module tb_pipelined_adder;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(16)) bus ();
   pipelined_adder_if #(.WIDTH(8))  bus8 ();
   pipelined_adder_if #(.WIDTH(32)) bus32 ();

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vecw_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_in  = 0;
   res_t        q[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_sum = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ordy);
      bus.in_valid  = iv;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      bus.out_ready = ordy;
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
      res_t        r;
      logic [16:0] t;
      t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      r.sum  = t[15:0];
      r.cout = t[16];
      r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
      return r;
   endfunction

   // One scoreboarded cycle: inputs change at the falling edge, handshakes evaluated just after.
   task automatic sb_cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic ordy);
      res_t e;
      @(negedge clk);
      if (prev_stall) begin
         check("stall_hold_valid", bus.out_valid, 1);
         check("stall_hold_sum", bus.sum, prev_sum);
      end
      drive(iv, a, b, cin, ordy);
      #1;
      check("sb_in_ready", bus.in_ready, !(bus.out_valid && !ordy));
      if (iv && bus.in_ready) begin
         q.push_back(model(a, b, cin));
         n_in++;
      end
      if (bus.out_valid && ordy) begin
         check("sb_out_pending", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("sb_sum", bus.sum, e.sum);
            check("sb_cout", bus.cout, e.cout);
            check("sb_ovf", bus.ovf, e.ovf);
         end
      end
      prev_stall = bus.out_valid && !ordy;
      prev_sum   = bus.sum;
   endtask

   vec_t  vt [12];
   vecw_t v8 [4];
   vecw_t v32[4];

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vt[3]  = '{16'h0001, 16'h0100, 1'b1, 16'h0102, 1'b0, 1'b0};
      vt[4]  = '{16'h0002, 16'h0200, 1'b0, 16'h0202, 1'b0, 1'b0};
      vt[5]  = '{16'h0003, 16'h0300, 1'b1, 16'h0304, 1'b0, 1'b0};
      vt[6]  = '{16'h0004, 16'h0400, 1'b0, 16'h0404, 1'b0, 1'b0};
      vt[7]  = '{16'h0005, 16'h0500, 1'b1, 16'h0506, 1'b0, 1'b0};
      vt[8]  = '{16'h0006, 16'h0600, 1'b0, 16'h0606, 1'b0, 1'b0};
      vt[9]  = '{16'h0007, 16'h0700, 1'b1, 16'h0708, 1'b0, 1'b0};
      vt[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[11] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

      v8[0]  = '{32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0};
      v8[1]  = '{32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1};
      v8[2]  = '{32'h12, 32'h34, 1'b1, 32'h47, 1'b0, 1'b0};
      v8[3]  = '{32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1};

      v32[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      v32[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      v32[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
      v32[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

      drive(1'b0, '0, '0, 1'b0, 1'b1);
      bus8.in_valid   = 1'b0;  bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
      bus32.in_valid  = 1'b0;  bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
      bus.sub = 1'b0; bus8.sub = 1'b0; bus32.sub = 1'b0;
`endif

      // Reset state
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_sum", bus.sum, 0);
      check("rst_cout", bus.cout, 0);
      check("rst_ovf", bus.ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", bus.in_ready, 1);
      check("rel_out_valid", bus.out_valid, 0);

      // Table: back-to-back beats, each result exactly S cycles later
      for (int c = 0; c < 12 + S + 1; c++) begin
         @(negedge clk);
         if (c >= S && c - S < 12) begin
            check($sformatf("tbl%0d_valid", c - S), bus.out_valid, 1);
            check($sformatf("tbl%0d_sum", c - S), bus.sum, vt[c-S].sum);
            check($sformatf("tbl%0d_cout", c - S), bus.cout, vt[c-S].cout);
            check($sformatf("tbl%0d_ovf", c - S), bus.ovf, vt[c-S].ovf);
         end else begin
            check($sformatf("tbl_idle%0d_valid", c), bus.out_valid, 0);
         end
         if (c < 12) drive(1'b1, vt[c].a, vt[c].b, vt[c].cin, 1'b1);
         else drive(1'b0, '0, '0, 1'b0, 1'b1);
      end

      // Reset mid-stream: one beat at the output, three behind it
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b1);
      end
      @(negedge clk);
      check("mid_pre_valid", bus.out_valid, 1);
      check("mid_pre_sum", bus.sum, 16'h1212);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_sum", bus.sum, 0);
      check("mid_rst_cout", bus.cout, 0);
      check("mid_rst_ovf", bus.ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_in_ready", bus.in_ready, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mid_no_stale", bus.out_valid, 0);
      end

      // Stall with a full pipe, then drain
      sb_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         sb_cycle(1'b1, 16'h1000 * 16'(i) + 16'(i), 16'h0F0F, i[0], 1'b0);
      for (int i = 0; i < 3; i++) begin
         sb_cycle(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_out_valid", bus.out_valid, 1);
      end
      for (int i = 0; i < 6; i++) sb_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("stall_drained", q.size(), 0);
      check("stall_accepted", n_in, 4);

      // Random handshakes against the model
      n_in = 0;
      for (int cyc = 0; cyc < 20000 && n_in < 1000; cyc++)
         sb_cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), $urandom_range(0, 2) != 0);
      for (int i = 0; i < S + 4; i++) sb_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("rand_accepted", n_in >= 1000, 1);
      check("rand_drained", q.size(), 0);

`ifdef PIPELINED_ADDER_SUB_EN
      // Subtract mode
      @(negedge clk);
      drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
      bus.sub = 1'b1;
      @(negedge clk);
      drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      bus.sub = 1'b0;
      repeat (S - 2) @(negedge clk);
      check("sub0_sum", bus.sum, 16'hFFFE);
      check("sub0_cout", bus.cout, 0);
      check("sub0_ovf", bus.ovf, 0);
      @(negedge clk);
      check("sub1_sum", bus.sum, 16'h7FFF);
      check("sub1_cout", bus.cout, 1);
      check("sub1_ovf", bus.ovf, 1);
`endif

      // Other geometries: latency equals STAGES
      for (int c = 0; c < 4 + 8 + 1; c++) begin
         @(negedge clk);
         if (c >= 1 && c - 1 < 4) begin
            check($sformatf("w8_%0d_valid", c - 1), bus8.out_valid, 1);
            check($sformatf("w8_%0d_sum", c - 1), bus8.sum, v8[c-1].sum);
            check($sformatf("w8_%0d_cout", c - 1), bus8.cout, v8[c-1].cout);
            check($sformatf("w8_%0d_ovf", c - 1), bus8.ovf, v8[c-1].ovf);
         end else begin
            check("w8_idle_valid", bus8.out_valid, 0);
         end
         if (c >= 8 && c - 8 < 4) begin
            check($sformatf("w32_%0d_valid", c - 8), bus32.out_valid, 1);
            check($sformatf("w32_%0d_sum", c - 8), bus32.sum, v32[c-8].sum);
            check($sformatf("w32_%0d_cout", c - 8), bus32.cout, v32[c-8].cout);
            check($sformatf("w32_%0d_ovf", c - 8), bus32.ovf, v32[c-8].ovf);
         end else begin
            check("w32_idle_valid", bus32.out_valid, 0);
         end
         if (c < 4) begin
            bus8.in_valid  = 1'b1;
            bus8.a         = v8[c].a[7:0];
            bus8.b         = v8[c].b[7:0];
            bus8.cin       = v8[c].cin;
            bus32.in_valid = 1'b1;
            bus32.a        = v32[c].a;
            bus32.b        = v32[c].b;
            bus32.cin      = v32[c].cin;
         end else begin
            bus8.in_valid  = 1'b0;
            bus32.in_valid = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
